hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Central stall/flush controller for the RV32IM 5-stage pipeline (S1 IF, S2 ID, S3 EX, S4 MEM, S5 WB). It sits directly downstream of the forwarding and branch-flush logic. It takes hazard conditions from S2–S4 and the multi-cycle MUL/DIV and data-memory handshakes, and drives the PC enable plus the enable and flush of every pipeline register (P_REG1 IF/ID, P_REG2 ID/EX, P_REG3 EX/MEM, P_REG4 MEM/WB). A small FSM tracks multi-cycle MUL/DIV stalls and a watchdog counter bounds data-memory wait.

## Interface
- MEM_TIMEOUT_CYC, 255: max consecutive MEM_BUSY cycles before MEM_TIMEOUT is raised (8-bit counter).
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- MEM_READ_S3  in  1  instruction in S3 is a load.
- REG_W_ADDR_S3  in  5  destination register of the S3 instruction.
- REG_ADDR1_S2, REG_ADDR2_S2  in  5 each  rs1/rs2 of the S2 instruction.
- USES_RS1_S2, USES_RS2_S2  in  1 each  S2 instruction actually reads rs1/rs2.
- BJ_SIG  in  1  branch taken or jump resolved in S3.
- MD_START_S3  in  1  S3 holds a MUL/DIV; held while it stays in S3.
- MD_DONE  in  1  MUL/DIV result valid (single-cycle pulse).
- MEM_BUSY  in  1  data memory not ready this cycle.
- PC_EN, P_REG1_EN, P_REG2_EN, P_REG3_EN, P_REG4_EN  out  1 each  update enables.
- FLUSH_P_REG1, FLUSH_P_REG2, FLUSH_P_REG3  out  1 each  load a NOP into that register at the next edge. Only acts when the matching enable is 1.
- MD_WAIT_STATE  out  1  FSM is in MD_WAIT.
- MEM_TIMEOUT  out  1  sticky error flag.

## Operation
- FSM states are RUN and MD_WAIT. The MEM_BUSY counter and the md_done_q latch are separate registers.
- Output priority, highest first: freeze, MD_WAIT, branch flush, load-use, normal.
- Freeze (MEM_BUSY=1, any state): all enables 0, all flushes 0, FSM state held.
- MD_WAIT, not frozen, and MD_DONE=0 with md_done_q=0:
  - PC_EN, P_REG1_EN, P_REG2_EN = 0.
  - P_REG3_EN = 1 and FLUSH_P_REG3 = 1 (bubble into MEM).
  - P_REG4_EN = 1.
- MD_WAIT, not frozen, and MD_DONE=1 or md_done_q=1: all enables 1 and no flush. Next state RUN; md_done_q cleared.
- MD_DONE arriving while frozen in MD_WAIT sets md_done_q, so completion is never lost.
- RUN with MD_START_S3=1 and MD_DONE=0: outputs as MD_WAIT. Next state MD_WAIT.
- RUN with MD_START_S3=1 and MD_DONE=1 (single-cycle MUL): no stall.
- Branch flush (RUN, BJ_SIG=1): all enables 1, FLUSH_P_REG1 = FLUSH_P_REG2 = 1. This overrides load-use.
- Load-use (RUN): condition is MEM_READ_S3 && REG_W_ADDR_S3 != 0 && ((USES_RS1_S2 && REG_ADDR1_S2 == REG_W_ADDR_S3) || (USES_RS2_S2 && REG_ADDR2_S2 == REG_W_ADDR_S3)).
  - PC_EN = 0, P_REG1_EN = 0.
  - FLUSH_P_REG2 = 1, with P_REG2_EN, P_REG3_EN, P_REG4_EN = 1.
  - Exactly one bubble is inserted. The condition clears naturally once the load reaches S4.
- Normal: all enables 1, no flush.
- Watchdog:
  - The counter increments each cycle MEM_BUSY=1 and saturates at MEM_TIMEOUT_CYC.
  - It clears to 0 on any cycle with MEM_BUSY=0.
  - MEM_TIMEOUT is set when the counter equals MEM_TIMEOUT_CYC with MEM_BUSY=1. It is cleared only by reset.

## Timing
- Reset (RESET=0, asynchronous):
  - state RUN; md_done_q = 0; counter = 0; MEM_TIMEOUT = 0.
  - While RESET=0, every enable and flush output is 0.
- All control outputs are combinational from state, registers and inputs, so they take effect at the same-cycle edge. There is no added pipeline latency.
- MUL/DIV stall of N cycles (MD_DONE in the Nth cycle after MD_START_S3 first seen): the S3 instruction advances at the edge ending that cycle. MEM receives N−1 bubbles.
- BJ_SIG held during a freeze: the flush is applied in the first cycle after MEM_BUSY drops.
- Reset mid-MD_WAIT: returns to RUN immediately and the pending md_done_q is discarded.

## Configuration
- HAZARD_STALL_COUNTERS_EN defined adds two output ports:
  - STALL_COUNT (32): +1 on every cycle with PC_EN=0 and RESET=1.
  - FLUSH_COUNT (32): +1 on every cycle with FLUSH_P_REG1=1.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: neither the ports nor the counters exist, and all other behaviour is identical.

## Test plan
- Load x5 in S3, S2 reads rs2=x5 with USES_RS2_S2=1 → one cycle of PC_EN=0, P_REG1_EN=0, FLUSH_P_REG2=1; the next cycle is normal. Same pattern with REG_W_ADDR_S3=0 → no stall.
- BJ_SIG=1 together with a load-use condition → FLUSH_P_REG1 = FLUSH_P_REG2 = 1, PC_EN=1.
- MD_START_S3=1, MD_DONE 4 cycles later → MD_WAIT_STATE high for 3 cycles, 3 FLUSH_P_REG3 bubbles, then RUN with all enables 1.
- MD_DONE pulses during MEM_BUSY=1 in MD_WAIT → all enables 0 while frozen. In the first cycle after MEM_BUSY drops: all enables 1, then RUN.
- MEM_BUSY held 256 cycles with MEM_TIMEOUT_CYC=255 → MEM_TIMEOUT rises at cycle 256 and stays 1 after MEM_BUSY drops, until RESET=0.
- RESET=0 asserted mid-MD_WAIT → every output 0 at once; after release, state is RUN and all enables are 1.

Source files
------------

// File: rtl/hazard_control_unit_if.sv
// Hazard condition inputs and stall/flush control outputs of hazard_control_unit.
// slave: the controller itself; master: the pipeline that supplies conditions.
interface hazard_control_unit_if;
    logic       mem_read_s3;
    logic [4:0] reg_w_addr_s3;
    logic [4:0] reg_addr1_s2;
    logic [4:0] reg_addr2_s2;
    logic       uses_rs1_s2;
    logic       uses_rs2_s2;
    logic       bj_sig;
    logic       md_start_s3;
    logic       md_done;
    logic       mem_busy;

    logic       pc_en;
    logic       p_reg1_en;
    logic       p_reg2_en;
    logic       p_reg3_en;
    logic       p_reg4_en;
    logic       flush_p_reg1;
    logic       flush_p_reg2;
    logic       flush_p_reg3;
    logic       md_wait_state;
    logic       mem_timeout;

    modport slave (
        input  mem_read_s3, reg_w_addr_s3, reg_addr1_s2, reg_addr2_s2,
        input  uses_rs1_s2, uses_rs2_s2, bj_sig, md_start_s3, md_done, mem_busy,
        output pc_en, p_reg1_en, p_reg2_en, p_reg3_en, p_reg4_en,
        output flush_p_reg1, flush_p_reg2, flush_p_reg3, md_wait_state, mem_timeout
    );

    modport master (
        output mem_read_s3, reg_w_addr_s3, reg_addr1_s2, reg_addr2_s2,
        output uses_rs1_s2, uses_rs2_s2, bj_sig, md_start_s3, md_done, mem_busy,
        input  pc_en, p_reg1_en, p_reg2_en, p_reg3_en, p_reg4_en,
        input  flush_p_reg1, flush_p_reg2, flush_p_reg3, md_wait_state, mem_timeout
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage RV32IM pipeline with MUL/DIV wait FSM and memory watchdog.
// Defining HAZARD_STALL_COUNTERS_EN adds the stall_count/flush_count performance counters.
module hazard_control_unit #(
    parameter int unsigned MemTimeoutCyc = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_control_unit_if.slave hz
`ifdef HAZARD_STALL_COUNTERS_EN
    ,
    output logic [31:0]          stall_count,
    output logic [31:0]          flush_count
`endif
);

    localparam logic [7:0] TimeoutMax = 8'(MemTimeoutCyc);

    typedef enum logic [0:0] {StRun, StMdWait} state_e;

    state_e     state_q, state_d;
    logic       md_done_q, md_done_d;
    logic [7:0] busy_cnt_q, busy_cnt_d;
    logic       timeout_q, timeout_d;
    logic       timeout_hit;
    logic       load_use;

    logic pc_en, p_reg1_en, p_reg2_en, p_reg3_en, p_reg4_en;
    logic flush_p_reg1, flush_p_reg2, flush_p_reg3;

    always_comb begin
        load_use = hz.mem_read_s3 && (hz.reg_w_addr_s3 != 5'd0) &&
                   ((hz.uses_rs1_s2 && (hz.reg_addr1_s2 == hz.reg_w_addr_s3)) ||
                    (hz.uses_rs2_s2 && (hz.reg_addr2_s2 == hz.reg_w_addr_s3)));
    end

    // Priority: reset, freeze, MD_WAIT, branch flush, load-use, normal.
    always_comb begin
        pc_en        = 1'b0;
        p_reg1_en    = 1'b0;
        p_reg2_en    = 1'b0;
        p_reg3_en    = 1'b0;
        p_reg4_en    = 1'b0;
        flush_p_reg1 = 1'b0;
        flush_p_reg2 = 1'b0;
        flush_p_reg3 = 1'b0;
        state_d      = state_q;
        md_done_d    = md_done_q;

        if (!rst_n) begin
            state_d   = StRun;
            md_done_d = 1'b0;
        end else if (hz.mem_busy) begin
            // Completion seen while frozen is remembered for the first unfrozen cycle.
            if (state_q == StMdWait && hz.md_done) begin
                md_done_d = 1'b1;
            end
        end else if (state_q == StMdWait) begin
            if (hz.md_done || md_done_q) begin
                pc_en     = 1'b1;
                p_reg1_en = 1'b1;
                p_reg2_en = 1'b1;
                p_reg3_en = 1'b1;
                p_reg4_en = 1'b1;
                state_d   = StRun;
                md_done_d = 1'b0;
            end else begin
                p_reg3_en    = 1'b1;
                flush_p_reg3 = 1'b1;
                p_reg4_en    = 1'b1;
            end
        end else if (hz.md_start_s3 && !hz.md_done) begin
            p_reg3_en    = 1'b1;
            flush_p_reg3 = 1'b1;
            p_reg4_en    = 1'b1;
            state_d      = StMdWait;
        end else if (hz.bj_sig) begin
            pc_en        = 1'b1;
            p_reg1_en    = 1'b1;
            p_reg2_en    = 1'b1;
            p_reg3_en    = 1'b1;
            p_reg4_en    = 1'b1;
            flush_p_reg1 = 1'b1;
            flush_p_reg2 = 1'b1;
        end else if (load_use) begin
            p_reg2_en    = 1'b1;
            p_reg3_en    = 1'b1;
            p_reg4_en    = 1'b1;
            flush_p_reg2 = 1'b1;
        end else begin
            pc_en     = 1'b1;
            p_reg1_en = 1'b1;
            p_reg2_en = 1'b1;
            p_reg3_en = 1'b1;
            p_reg4_en = 1'b1;
        end
    end

    always_comb begin
        timeout_hit = rst_n && hz.mem_busy && (busy_cnt_q == TimeoutMax);
        if (!hz.mem_busy) begin
            busy_cnt_d = 8'd0;
        end else if (busy_cnt_q == TimeoutMax) begin
            busy_cnt_d = busy_cnt_q;
        end else begin
            busy_cnt_d = busy_cnt_q + 8'd1;
        end
        timeout_d = timeout_q | timeout_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            md_done_q  <= 1'b0;
            busy_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            md_done_q  <= md_done_d;
            busy_cnt_q <= busy_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign hz.pc_en         = pc_en;
    assign hz.p_reg1_en     = p_reg1_en;
    assign hz.p_reg2_en     = p_reg2_en;
    assign hz.p_reg3_en     = p_reg3_en;
    assign hz.p_reg4_en     = p_reg4_en;
    assign hz.flush_p_reg1  = flush_p_reg1;
    assign hz.flush_p_reg2  = flush_p_reg2;
    assign hz.flush_p_reg3  = flush_p_reg3;
    assign hz.md_wait_state = (state_q == StMdWait);
    // Flag is visible in the same cycle the limit is reached, then held by timeout_q.
    assign hz.mem_timeout   = timeout_q | timeout_hit;

`ifdef HAZARD_STALL_COUNTERS_EN
    logic [31:0] stall_count_q, flush_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= 32'd0;
            flush_count_q <= 32'd0;
        end else begin
            if (!pc_en) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
            if (flush_p_reg1) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: table vectors plus multi-cycle sequences.
module tb_hazard_control_unit;

    typedef struct packed {
        logic       mr;
        logic [4:0] w;
        logic [4:0] a1;
        logic [4:0] a2;
        logic       u1;
        logic       u2;
        logic       bj;
        logic       mds;
        logic       mdd;
        logic       busy;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [9:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } sb_t;

    // {pc, p1, p2, p3, p4, f1, f2, f3, md_wait, timeout}
    localparam logic [9:0] ZERO  = 10'b00000_000_00;
    localparam logic [9:0] NORM  = 10'b11111_000_00;
    localparam logic [9:0] LU    = 10'b00111_010_00;
    localparam logic [9:0] BR    = 10'b11111_110_00;
    localparam logic [9:0] MDS   = 10'b00011_001_00;
    localparam logic [9:0] MDW   = 10'b00011_001_10;
    localparam logic [9:0] MDEND = 10'b11111_000_10;
    localparam logic [9:0] FRZW  = 10'b00000_000_10;
    localparam logic [9:0] TO    = 10'b00000_000_01;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    sb_t  sb[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    hazard_control_unit_if hif ();

`ifdef HAZARD_STALL_COUNTERS_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    hazard_control_unit #(.MemTimeoutCyc(255)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hz         (hif)
`ifdef HAZARD_STALL_COUNTERS_EN
        ,
        .stall_count(stall_count),
        .flush_count(flush_count)
`endif
    );

    function automatic in_t mk(bit mr, int w, int a1, int a2, bit u1, bit u2,
                               bit bj, bit mds, bit mdd, bit busy);
        in_t v;
        v.mr = mr;   v.w = 5'(w); v.a1 = 5'(a1); v.a2 = 5'(a2);
        v.u1 = u1;   v.u2 = u2;   v.bj = bj;     v.mds = mds;
        v.mdd = mdd; v.busy = busy;
        return v;
    endfunction

    task automatic drive(input in_t v);
        hif.mem_read_s3   = v.mr;
        hif.reg_w_addr_s3 = v.w;
        hif.reg_addr1_s2  = v.a1;
        hif.reg_addr2_s2  = v.a2;
        hif.uses_rs1_s2   = v.u1;
        hif.uses_rs2_s2   = v.u2;
        hif.bj_sig        = v.bj;
        hif.md_start_s3   = v.mds;
        hif.md_done       = v.mdd;
        hif.mem_busy      = v.busy;
    endtask

    task automatic check_out();
        sb_t        e;
        logic [9:0] act;
        act = {hif.pc_en, hif.p_reg1_en, hif.p_reg2_en, hif.p_reg3_en, hif.p_reg4_en,
               hif.flush_p_reg1, hif.flush_p_reg2, hif.flush_p_reg3,
               hif.md_wait_state, hif.mem_timeout};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %b required an expected entry", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %b required %b", e.name, act, e.exp);
            end
        end
    endtask

    task automatic step(input string name, input in_t v, input logic [9:0] exp);
        drive(v);
        sb.push_back('{name, exp});
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    in_t idle;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1);
    end

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        vecs[0]  = '{"normal_idle",      idle,                                   NORM};
        vecs[1]  = '{"load_use_rs2",     mk(1, 5, 0, 5, 0, 1, 0, 0, 0, 0),       LU};
        vecs[2]  = '{"load_after_bubble", mk(0, 5, 0, 5, 0, 1, 0, 0, 0, 0),      NORM};
        vecs[3]  = '{"load_x0_no_stall", mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0),       NORM};
        vecs[4]  = '{"load_use_rs1",     mk(1, 7, 7, 3, 1, 0, 0, 0, 0, 0),       LU};
        vecs[5]  = '{"match_unused",     mk(1, 7, 7, 7, 0, 0, 0, 0, 0, 0),       NORM};
        vecs[6]  = '{"load_no_match",    mk(1, 9, 8, 10, 1, 1, 0, 0, 0, 0),      NORM};
        vecs[7]  = '{"branch_over_lu",   mk(1, 5, 0, 5, 0, 1, 1, 0, 0, 0),       BR};
        vecs[8]  = '{"branch_alone",     mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0),       BR};
        vecs[9]  = '{"md_single_cycle",  mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0),       NORM};
        vecs[10] = '{"freeze_branch",    mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1),       ZERO};
        vecs[11] = '{"branch_after_frz", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0),       BR};

        drive(idle);
        #2;
        sb.push_back('{"in_reset", ZERO});
        check_out();
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].name, vecs[i].in, vecs[i].exp);
        end

        // MUL/DIV with done four cycles after start.
        step("md4_c1", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), MDS);
        step("md4_c2", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), MDW);
        step("md4_c3", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), MDW);
        step("md4_c4", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), MDEND);
        step("md4_run", idle, NORM);

        // Done pulse while frozen in MD_WAIT.
        step("mdf_start", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), MDS);
        step("mdf_frz_done", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), FRZW);
        step("mdf_frz_hold", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), FRZW);
        step("mdf_release", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), MDEND);
        step("mdf_run", idle, NORM);

        // Reset mid-MD_WAIT with a latched completion pending.
        step("mdr_start", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), MDS);
        step("mdr_frz_done", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), FRZW);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        #1 rst_n = 1'b0;
        #1;
        sb.push_back('{"mdr_reset_async", ZERO});
        check_out();
        @(posedge clk);
        drive(idle);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("mdr_after_reset", idle, NORM);
        step("mdr_restart", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), MDS);
        step("mdr_no_stale_done", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), MDW);
        step("mdr_done", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), MDEND);
        step("mdr_run", idle, NORM);

        // Watchdog: 256 busy cycles, flag rises in cycle 256 and is sticky.
        for (int i = 1; i <= 256; i++) begin
            step($sformatf("busy_c%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
                 (i == 256) ? TO : ZERO);
        end
        for (int i = 0; i < 3; i++) begin
            step($sformatf("timeout_sticky_%0d", i), idle, NORM | TO);
        end
        step("timeout_sticky_busy1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), TO);
        #1 rst_n = 1'b0;
        #1;
        sb.push_back('{"timeout_reset", ZERO});
        check_out();
        @(negedge clk);
        drive(idle);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("timeout_cleared", idle, NORM);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
